// File: rtl/md5_search_ctrl.sv
// Brute-force search sequencer for a pipelined md5core: issues lowercase candidates and matches retiring digests.
// Optional MD5_SEARCH_MULTI_MATCH_EN: keep searching after a match, pulse found per hit, report any_match in DONE.
module md5_search_ctrl #(
    parameter int MAX_LEN  = 8,
    parameter int PIPE_LAT = 65,
    parameter int CNT_W    = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [127:0]         target,
    input  logic [3:0]           pw_len,
    output logic                 busy,
    output logic                 found,
    output logic                 done,
    output logic [8*MAX_LEN-1:0] found_msg,
    output logic [CNT_W-1:0]     cand_count,
    output logic [447:0]         md5_message,
    output logic [63:0]          md5_length,
    input  logic [127:0]         md5_hash,
    input  logic [511:0]         md5_message_in
);

    localparam int MW = 8 * MAX_LEN;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FOUND, S_DONE} state_t;

    state_t              state, state_next;
    logic [127:0]        target_q;
    logic [3:0]          len_q;
    logic [MW-1:0]       issue_odo, retire_odo;
    logic [MW:0]         issue_step, retire_step;
    logic [PIPE_LAT-1:0] valid_pipe, pipe_after;
    logic                accept, len_bad, issue, retiring, match_hit, drained;
    logic                unused_msg_in;
`ifdef MD5_SEARCH_MULTI_MATCH_EN
    logic                any_match;
`endif

    // Odometer step over the active chars; MSB of the result is the carry out of the first char.
    function automatic logic [MW:0] odo_advance(input logic [MW-1:0] cur, input logic [3:0] len);
        logic [MW-1:0] nxt;
        logic          carry;
        nxt   = cur;
        carry = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (carry && (i < int'(len))) begin
                if (cur[8*i +: 8] == 8'h7a) begin
                    nxt[8*i +: 8] = 8'h61;
                end else begin
                    nxt[8*i +: 8] = cur[8*i +: 8] + 8'd1;
                    carry         = 1'b0;
                end
            end
        end
        return {carry, nxt};
    endfunction

    function automatic logic [MW-1:0] odo_first(input logic [3:0] len);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) v[8*i +: 8] = 8'h61;
        end
        return v;
    endfunction

    assign len_bad       = (pw_len == 4'd0) || (int'(pw_len) > MAX_LEN);
    assign issue_step    = odo_advance(issue_odo, len_q);
    assign retire_step   = odo_advance(retire_odo, len_q);
    assign pipe_after    = valid_pipe << 1;
    assign drained       = (pipe_after == '0);
    assign retiring      = valid_pipe[PIPE_LAT-1] && ((state == S_RUN) || (state == S_DRAIN));
    assign match_hit     = retiring && (md5_hash == target_q);
    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign md5_message   = 448'(issue_odo);
    assign unused_msg_in = ^md5_message_in;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            S_IDLE, S_FOUND, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = len_bad ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                issue = 1'b1;
`ifdef MD5_SEARCH_MULTI_MATCH_EN
                if (issue_step[MW]) state_next = S_DRAIN;
`else
                if (match_hit)           state_next = S_FOUND;
                else if (issue_step[MW]) state_next = S_DRAIN;
`endif
            end
            S_DRAIN: begin
`ifdef MD5_SEARCH_MULTI_MATCH_EN
                if (drained) state_next = S_DONE;
`else
                if (match_hit)    state_next = S_FOUND;
                else if (drained) state_next = S_DONE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The retire odometer moves only on valid retirements, so it always names the digest being compared.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_pipe <= '0;
            target_q   <= '0;
            len_q      <= '0;
            issue_odo  <= '0;
            retire_odo <= '0;
            cand_count <= '0;
            found_msg  <= '0;
            md5_length <= '0;
            found      <= 1'b0;
            done       <= 1'b0;
`ifdef MD5_SEARCH_MULTI_MATCH_EN
            any_match  <= 1'b0;
`endif
        end else begin
            valid_pipe <= accept ? '0 : (pipe_after | PIPE_LAT'(issue));
            if (accept) begin
                target_q   <= target;
                len_q      <= pw_len;
                cand_count <= '0;
                found_msg  <= '0;
                issue_odo  <= len_bad ? '0 : odo_first(pw_len);
                retire_odo <= odo_first(pw_len);
                md5_length <= len_bad ? '0 : {57'd0, pw_len, 3'b000};
            end else begin
                if (issue) begin
                    cand_count <= cand_count + CNT_W'(1);
                    if (!issue_step[MW]) issue_odo <= issue_step[MW-1:0];
                end
                if (retiring)  retire_odo <= retire_step[MW-1:0];
                if (match_hit) found_msg  <= retire_odo;
            end
`ifdef MD5_SEARCH_MULTI_MATCH_EN
            any_match <= accept ? 1'b0 : (any_match | match_hit);
            found     <= match_hit ||
                         ((state_next == S_DONE) && !accept && (any_match || match_hit));
            done      <= (state_next == S_DONE);
`else
            found     <= (state_next == S_FOUND);
            done      <= (state_next == S_DONE);
`endif
        end
    end

endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl: a stand-in md5core (fixed latency, reversible toy digest) plus
// a keyspace model that predicts hit cycles, counts and messages from base-26 arithmetic.
module tb_md5_search_ctrl;

    localparam int MAX_LEN  = 8;
    localparam int PIPE_LAT = 65;
    localparam int CNT_W    = 40;

    logic                 clk = 1'b0;
    logic                 reset, start;
    logic [127:0]         target;
    logic [3:0]           pw_len;
    logic                 busy, found, done;
    logic [8*MAX_LEN-1:0] found_msg;
    logic [CNT_W-1:0]     cand_count;
    logic [447:0]         md5_message;
    logic [63:0]          md5_length;
    logic [127:0]         md5_hash;
    logic [511:0]         md5_message_in;
    logic [447:0]         core_pipe [PIPE_LAT];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    md5_search_ctrl #(.MAX_LEN(MAX_LEN), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .target(target), .pw_len(pw_len),
        .busy(busy), .found(found), .done(done), .found_msg(found_msg),
        .cand_count(cand_count), .md5_message(md5_message), .md5_length(md5_length),
        .md5_hash(md5_hash), .md5_message_in(md5_message_in)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] fake_hash(input logic [447:0] m);
        return {~m[63:0], m[63:0] ^ 64'h0123_4567_89ab_cdef};
    endfunction

    // Candidate number k of a len-char search, as right-justified lowercase bytes.
    function automatic logic [63:0] cand_of(input longint k, input int len);
        logic [63:0] v;
        longint      r;
        v = '0;
        r = k;
        for (int i = 0; i < len; i++) begin
            v[8*i +: 8] = 8'(64'h61 + (r % 26));
            r = r / 26;
        end
        return v;
    endfunction

    function automatic longint keyspace(input int len);
        longint r;
        r = 1;
        for (int i = 0; i < len; i++) r = r * 26;
        return r;
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= md5_message;
        for (int i = 1; i < PIPE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end

    assign md5_hash       = fake_hash(core_pipe[PIPE_LAT-1]);
    assign md5_message_in = {md5_length, core_pipe[PIPE_LAT-1]};

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Called on a negedge (cycle T); returns on the negedge of cycle T+1.
    task automatic applyStimulus(input logic [3:0] len, input logic [127:0] tgt);
        pw_len = len;
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_end(input int from_n, input int limit,
                            output int hit_at, output int b_first, output int b_last);
        int n;
        bit seen;
        n = from_n; hit_at = -1; b_first = -1; b_last = -1; seen = 0;
        while (!seen && n <= limit) begin
            if (busy) begin
                if (b_first < 0) b_first = n;
                b_last = n;
            end
            if (found || done) begin
                hit_at = n;
                seen   = 1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic expect_match(input int len, input longint k);
        longint      n_keys, exp_cnt, last_iss;
        logic [63:0] word;
        int          hit, bf, bl;
        n_keys   = keyspace(len);
        word     = cand_of(k, len);
        exp_cnt  = (k + PIPE_LAT + 1 < n_keys) ? k + PIPE_LAT + 1 : n_keys;
        last_iss = (exp_cnt < n_keys) ? exp_cnt : n_keys - 1;
        applyStimulus(4'(len), fake_hash(448'(word)));
        wait_end(1, int'(k) + PIPE_LAT + 40, hit, bf, bl);
        checkOutput("found_cycle", 128'(hit), 128'(k + 2 + PIPE_LAT));
        checkOutput("found_msg", found_msg, word);
        checkOutput("cand_count", cand_count, 128'(exp_cnt));
        repeat (5) tick;
        checkOutput("found_held", found, 1);
        checkOutput("no_done", done, 0);
        checkOutput("stop_count", cand_count, 128'(exp_cnt));
        checkOutput("stop_msg", md5_message, 448'(cand_of(last_iss, len)));
    endtask

    initial begin
        int hit, bf, bl, len;
        longint k;
        for (int i = 0; i < PIPE_LAT; i++) core_pipe[i] = '0;
        reset = 1'b1; start = 1'b0; pw_len = '0; target = '0;
        repeat (3) tick;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_found", found, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_msg", md5_message, 0);
        checkOutput("rst_len", md5_length, 0);
        checkOutput("rst_count", cand_count, 0);
        reset = 1'b0;
        tick;

        $display("[TB] abc search");
        expect_match(3, 28);
        checkOutput("abc_bytes", found_msg[23:0], 24'h616263);

        $display("[TB] single-char z search");
        expect_match(1, 25);
        checkOutput("z_byte", found_msg[7:0], 8'h7a);

        $display("[TB] len 1 exhaustion");
        applyStimulus(4'd1, 128'h0);
        wait_end(1, 27 + PIPE_LAT + 20, hit, bf, bl);
        checkOutput("ex1_cycle", 128'(hit), 27 + PIPE_LAT);
        checkOutput("ex1_done", done, 1);
        checkOutput("ex1_found", found, 0);
        checkOutput("ex1_count", cand_count, 26);
        checkOutput("ex1_busy_first", 128'(bf), 1);
        checkOutput("ex1_busy_last", 128'(bl), 26 + PIPE_LAT);

        $display("[TB] len 2 wrong-length target with ignored restart");
        applyStimulus(4'd2, fake_hash(448'(cand_of(0, 1))));
        checkOutput("ex2_len_early", md5_length, 16);
        repeat (49) tick;
        checkOutput("ex2_count_mid", cand_count, 49);
        pw_len = 4'd1; target = '0; start = 1'b1;
        tick;
        start = 1'b0;
        checkOutput("ex2_count_after_start", cand_count, 50);
        checkOutput("ex2_len_mid", md5_length, 16);
        wait_end(51, 677 + PIPE_LAT + 20, hit, bf, bl);
        checkOutput("ex2_cycle", 128'(hit), 677 + PIPE_LAT);
        checkOutput("ex2_done", done, 1);
        checkOutput("ex2_found", found, 0);
        checkOutput("ex2_count", cand_count, 676);
        checkOutput("ex2_len_end", md5_length, 16);

        $display("[TB] invalid lengths");
        applyStimulus(4'd0, 128'h0);
        wait_end(1, 5, hit, bf, bl);
        checkOutput("len0_cycle", 128'(hit), 1);
        checkOutput("len0_count", cand_count, 0);
        checkOutput("len0_busy", 128'(bf), 128'(-1));
        applyStimulus(4'd9, 128'h0);
        wait_end(1, 5, hit, bf, bl);
        checkOutput("len9_cycle", 128'(hit), 1);
        checkOutput("len9_done", done, 1);

        $display("[TB] reset mid-search");
        applyStimulus(4'd3, fake_hash(448'(cand_of(28, 3))));
        repeat (9) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_count", cand_count, 0);
        checkOutput("mid_rst_msg", md5_message, 0);
        expect_match(3, 4);
        expect_match(1, 25);

        $display("[TB] random targets");
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 3));
            if (len == 3) k = longint'($urandom_range(0, 1500));
            else          k = longint'($urandom_range(0, 32'(keyspace(len) - 1)));
            expect_match(len, k);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
